// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Brief    : Frame-buffer RAM port arbiter (display reads vs. result writes)
//            with vblank-aligned frame commit. Define FB_DOUBLE_BUFFER_EN for
//            two banks; otherwise a single bank written only during blanking.
// Revision : 1.0
// ============================================================================
module vga_fb_arbiter #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              commit_req,
    output logic              commit_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel_data,
    output logic              pixel_valid,
    output logic              disp_bank,
    output logic [7:0]        frame_cnt,
    output logic              err_oob
);

    localparam logic [ADDR_W:0] c_PIXELS = (ADDR_W+1)'(H_VISIBLE * V_VISIBLE);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_SWAP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_vblank_q;
    logic               r_disp_bank;
    logic               r_commit_ack;
    logic [7:0]         r_frame_cnt;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W:0]    r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_pixel_valid;
    logic               r_err_oob;

    logic               w_disp_slot;
    logic               w_vb_rise;
    logic               w_wr_ready;
    logic               w_wr_fire;
    logic               w_wr_oob;
    logic               w_wr_bank;

`ifdef FB_DOUBLE_BUFFER_EN
    localparam logic c_BANK_TOGGLE = 1'b1;
    assign w_wr_ready = reset_n && (r_state == S_RUN) && !w_disp_slot;
    assign w_wr_bank  = ~r_disp_bank;
`else
    // Single bank: writes confined to blanking so the visible image never tears.
    localparam logic c_BANK_TOGGLE = 1'b0;
    assign w_wr_ready = reset_n && (r_state == S_RUN) && (hblank || vblank);
    assign w_wr_bank  = 1'b0;
`endif

    assign w_disp_slot = clk_en && !hblank && !vblank;
    assign w_vb_rise   = vblank && !r_vblank_q;
    assign w_wr_fire   = wr_valid && w_wr_ready;
    assign w_wr_oob    = ({1'b0, wr_addr} >= c_PIXELS);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_RUN;
            r_vblank_q   <= 1'b0;
            r_disp_bank  <= 1'b0;
            r_commit_ack <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_vblank_q   <= vblank;
            r_commit_ack <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (commit_req) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Bank flip lands on the first cycle of vertical blanking.
                    if (w_vb_rise) begin
                        r_state      <= S_SWAP;
                        r_commit_ack <= 1'b1;
                        r_disp_bank  <= r_disp_bank ^ c_BANK_TOGGLE;
                        r_frame_cnt  <= r_frame_cnt + 8'd1;
                    end
                end
                S_SWAP: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_addr     <= '0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_pixel_valid <= 1'b0;
            r_err_oob     <= 1'b0;
        end else begin
            r_pixel_valid <= r_mem_en && !r_mem_we;

            if (vblank) begin
                r_rd_addr <= '0;
            end else if (w_disp_slot) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end

            if (w_disp_slot) begin
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= {r_disp_bank, r_rd_addr};
            end else if (w_wr_fire && !w_wr_oob) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= {w_wr_bank, wr_addr};
                r_mem_wdata <= wr_data;
            end else begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
            end

            // Out-of-range writes still complete the handshake but never reach RAM.
            if (w_wr_fire && w_wr_oob) begin
                r_err_oob <= 1'b1;
            end
        end
    end

    assign wr_ready    = w_wr_ready;
    assign commit_ack  = r_commit_ack;
    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign pixel_data  = r_pixel_valid ? mem_rdata : '0;
    assign pixel_valid = r_pixel_valid;
    assign disp_bank   = r_disp_bank;
    assign frame_cnt   = r_frame_cnt;
    assign err_oob     = r_err_oob;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_arbiter
// Brief    : Self-checking bench for vga_fb_arbiter (either bank build).
// Revision : 1.0
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam logic c_DB = 1'b1;
`else
    localparam logic c_DB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              clk_en;
    logic              hblank;
    logic              vblank;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              commit_req;
    logic              commit_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pixel_data;
    logic              pixel_valid;
    logic              disp_bank;
    logic [7:0]        frame_cnt;
    logic              err_oob;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .H_VISIBLE(640),
        .V_VISIBLE(480),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .hblank     (hblank),
        .vblank     (vblank),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .commit_req (commit_req),
        .commit_ack (commit_ack),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pixel_data (pixel_data),
        .pixel_valid(pixel_valid),
        .disp_bank  (disp_bank),
        .frame_cnt  (frame_cnt),
        .err_oob    (err_oob)
    );

    // Preloaded RAM: each word is a fixed function of its address.
    always_ff @(posedge clk) begin
        if (mem_en && !mem_we) begin
            mem_rdata <= mem_addr[11:0] ^ 12'h5A5;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic ce;
        logic hb;
        logic vb;
        logic wv;
        logic rdy;
        logic en;
        logic we;
    } vec_t;

    vec_t vecs [8];
    int   acc;

    initial begin
        //            ce    hb    vb    wv    rdy   en    we
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, c_DB, c_DB, c_DB};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, c_DB, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset_n = 1'b0; clk_en = 1'b0; hblank = 1'b1; vblank = 1'b0;
        wr_valid = 1'b1; wr_addr = '0; wr_data = '0; commit_req = 1'b0;
        repeat (3) next_cycle();

        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_commit_ack", commit_ack, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_pixel_data", pixel_data, 0);
        chk("rst_pixel_valid", pixel_valid, 0);
        chk("rst_disp_bank", disp_bank, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_oob", err_oob, 0);
        reset_n = 1'b1;

        // Active video, pixel enable every 4th cycle, writer always requesting.
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            clk_en = (c % 4 == 0); hblank = 1'b0; vblank = 1'b0;
            wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 12'hABC;
            #1;
            chk($sformatf("px%0d_wr_ready", c), wr_ready, (c % 4 == 0) ? 0 : c_DB);
            if (wr_valid && wr_ready) acc++;
            next_cycle();
            chk($sformatf("px%0d_mem_en", c), mem_en, (c % 4 == 0) ? 1 : c_DB);
            chk($sformatf("px%0d_mem_we", c), mem_we, (c % 4 == 0) ? 0 : c_DB);
            if (c % 4 == 0) begin
                chk($sformatf("px%0d_rd_addr", c), mem_addr, {1'b0, 19'(c / 4)});
            end else begin
                chk($sformatf("px%0d_wr_addr", c), mem_en ? mem_addr : 20'd0,
                    c_DB ? {1'b1, 19'd5} : 20'd0);
                chk($sformatf("px%0d_wr_data", c), mem_we ? mem_wdata : 12'd0,
                    c_DB ? 12'hABC : 12'd0);
            end
            chk($sformatf("px%0d_pixel_valid", c), pixel_valid, (c % 4 == 1));
            if (c % 4 == 1) begin
                chk($sformatf("px%0d_pixel_data", c), pixel_data, 12'(c / 4) ^ 12'h5A5);
            end
        end
        chk("px_accepts", acc, c_DB ? 9 : 0);

        // Grant table in RUN.
        for (int i = 0; i < 8; i++) begin
            clk_en = vecs[i].ce; hblank = vecs[i].hb; vblank = vecs[i].vb;
            wr_valid = vecs[i].wv; wr_addr = 19'd7; wr_data = 12'h3C3;
            #1;
            chk($sformatf("tbl%0d_wr_ready", i), wr_ready, vecs[i].rdy);
            next_cycle();
            chk($sformatf("tbl%0d_mem_en", i), mem_en, vecs[i].en);
            chk($sformatf("tbl%0d_mem_we", i), mem_we, vecs[i].we);
        end

        // Commit mid-frame, swap at the next vblank rising edge.
        clk_en = 1'b0; hblank = 1'b0; vblank = 1'b0; wr_valid = 1'b0; commit_req = 1'b1;
        #1 chk("cm_run_ready", wr_ready, c_DB);
        next_cycle();
        hblank = 1'b1;
        #1 chk("cm_wait_ready_hb", wr_ready, 0);
        next_cycle();
        hblank = 1'b0;
        #1 chk("cm_wait_ready", wr_ready, 0);
        chk("cm_ack_early", commit_ack, 0);
        next_cycle();
        vblank = 1'b1;
        #1 chk("cm_ack_at_edge", commit_ack, 0);
        chk("cm_edge_ready", wr_ready, 0);
        next_cycle();
        chk("cm_ack", commit_ack, 1);
        chk("cm_bank", disp_bank, c_DB);
        chk("cm_frame", frame_cnt, 1);
        chk("cm_swap_ready", wr_ready, 0);
        commit_req = 1'b0;
        next_cycle();
        chk("cm_ack_pulse", commit_ack, 0);
        chk("cm_run_ready_vb", wr_ready, 1);

        // Second commit during the same vblank waits for the next frame.
        commit_req = 1'b1;
        next_cycle();
        repeat (3) begin
            chk("cm2_no_ack", commit_ack, 0);
            chk("cm2_wait_ready", wr_ready, 0);
            next_cycle();
        end
        vblank = 1'b0;
        next_cycle();
        chk("cm2_no_ack_active", commit_ack, 0);
        vblank = 1'b1;
        next_cycle();
        chk("cm2_ack", commit_ack, 1);
        chk("cm2_frame", frame_cnt, 2);
        chk("cm2_bank", disp_bank, 0);
        commit_req = 1'b0;
        next_cycle();

        // Address range boundary.
        hblank = 1'b1; vblank = 1'b0; wr_valid = 1'b1;
        wr_addr = 19'd307199; wr_data = 12'h123;
        #1 chk("oob_last_ready", wr_ready, 1);
        next_cycle();
        chk("oob_last_en", mem_en, 1);
        chk("oob_last_addr", mem_addr, {c_DB, 19'd307199});
        chk("oob_last_err", err_oob, 0);
        wr_addr = 19'd307200;
        #1 chk("oob_ready", wr_ready, 1);
        next_cycle();
        chk("oob_en", mem_en, 0);
        chk("oob_err", err_oob, 1);
        wr_valid = 1'b0;
        repeat (3) next_cycle();
        chk("oob_sticky", err_oob, 1);

        // Reset in the middle of active video.
        hblank = 1'b0; vblank = 1'b0; clk_en = 1'b1;
        next_cycle();
        next_cycle();
        reset_n = 1'b0;
        #1 chk("mr_wr_ready", wr_ready, 0);
        next_cycle();
        chk("mr_mem_en", mem_en, 0);
        chk("mr_mem_addr", mem_addr, 0);
        chk("mr_pixel_valid", pixel_valid, 0);
        chk("mr_pixel_data", pixel_data, 0);
        chk("mr_frame_cnt", frame_cnt, 0);
        chk("mr_err_oob", err_oob, 0);
        chk("mr_commit_ack", commit_ack, 0);
        reset_n = 1'b1;
        next_cycle();
        chk("mr_restart_en", mem_en, 1);
        chk("mr_restart_addr", mem_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
